// File: rtl/reset_sequencer.sv
// Reset sequencer for the PLL clock domain: waits for a stable PLL lock, then releases
// the peripheral reset followed by the J1 core reset, and counts lock losses seen in RUN.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 4200,
  parameter int STAGGER_CYCLES = 16,
  parameter int HOLD_CYCLES    = 8,
  parameter int LOSS_CNT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pllLocked,
  input  logic                      resetReq,
  output logic                      periphReset,
  output logic                      coreReset,
  output logic                      isReady,
  output logic [LOSS_CNT_WIDTH-1:0] lockLossCount
);

  localparam int MaxAB     = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
  localparam int MaxCycles = (MaxAB > HOLD_CYCLES) ? MaxAB : HOLD_CYCLES;
  localparam int CntWidth  = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntWidth-1:0] StableLast  = CntWidth'(STABLE_CYCLES - 1);
  localparam logic [CntWidth-1:0] StaggerLast = CntWidth'(STAGGER_CYCLES - 1);
  localparam logic [CntWidth-1:0] HoldLast    = CntWidth'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    WaitLock,
    Stabilize,
    ReleasePeriph,
    Run,
    Hold
  } stateT;

  stateT                     stateQ;
  logic [CntWidth-1:0]       cntQ;
  logic [SYNC_STAGES-1:0]    syncQ;
  logic [SYNC_STAGES-1:0]    syncD;
  logic                      periphResetQ;
  logic                      coreResetQ;
  logic                      isReadyQ;
  logic [LOSS_CNT_WIDTH-1:0] lossCntQ;
  logic [LOSS_CNT_WIDTH-1:0] lossCntD;
  logic                      lockSync;

  assign syncD    = {syncQ[SYNC_STAGES-2:0], pllLocked};
  assign lockSync = syncQ[SYNC_STAGES-1];
  assign lossCntD = (&lossCntQ) ? lossCntQ : lossCntQ + 1'b1;

  // pllLocked is asynchronous to clk, so it only enters the FSM through this chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncQ <= '0;
    end else begin
      syncQ <= syncD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ       <= WaitLock;
      cntQ         <= '0;
      periphResetQ <= 1'b1;
      coreResetQ   <= 1'b1;
      isReadyQ     <= 1'b0;
      lossCntQ     <= '0;
    end else begin
      // A loss in RUN is counted even when a simultaneous resetReq steers us to HOLD.
      if (stateQ == Run && !lockSync) begin
        lossCntQ <= lossCntD;
      end
      if (resetReq) begin
        stateQ       <= Hold;
        cntQ         <= '0;
        periphResetQ <= 1'b1;
        coreResetQ   <= 1'b1;
        isReadyQ     <= 1'b0;
      end else begin
        case (stateQ)
          WaitLock: begin
            periphResetQ <= 1'b1;
            coreResetQ   <= 1'b1;
            isReadyQ     <= 1'b0;
            if (lockSync) begin
              stateQ <= Stabilize;
              cntQ   <= '0;
            end
          end
          Stabilize: begin
            if (!lockSync) begin
              stateQ <= WaitLock;
            end else if (cntQ == StableLast) begin
              stateQ       <= ReleasePeriph;
              periphResetQ <= 1'b0;
              cntQ         <= '0;
            end else begin
              cntQ <= cntQ + 1'b1;
            end
          end
          ReleasePeriph: begin
            if (!lockSync) begin
              stateQ       <= WaitLock;
              periphResetQ <= 1'b1;
            end else if (cntQ == StaggerLast) begin
              stateQ     <= Run;
              coreResetQ <= 1'b0;
              isReadyQ   <= 1'b1;
            end else begin
              cntQ <= cntQ + 1'b1;
            end
          end
          Run: begin
            if (!lockSync) begin
              stateQ       <= WaitLock;
              periphResetQ <= 1'b1;
              coreResetQ   <= 1'b1;
              isReadyQ     <= 1'b0;
            end
          end
          Hold: begin
            if (cntQ == HoldLast) begin
              stateQ <= WaitLock;
            end else begin
              cntQ <= cntQ + 1'b1;
            end
          end
          default: begin
            stateQ <= WaitLock;
          end
        endcase
      end
    end
  end

  assign periphReset   = periphResetQ;
  assign coreReset     = coreResetQ;
  assign isReady       = isReadyQ;
  assign lockLossCount = lossCntQ;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues each expected output change with
// the edge it should follow; a negedge monitor pops and compares whenever the outputs move.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pllLocked;
  logic       resetReq;
  logic       periphReset;
  logic       coreReset;
  logic       isReady;
  logic [3:0] lockLossCount;

  typedef struct {
    int         edgeNum;
    logic [6:0] outs;
  } expT;

  expT        sb[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         evIdx = 0;
  logic [6:0] prevOuts = 'x;

  reset_sequencer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .STAGGER_CYCLES(4),
    .HOLD_CYCLES   (3),
    .LOSS_CNT_WIDTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pllLocked    (pllLocked),
    .resetReq     (resetReq),
    .periphReset  (periphReset),
    .coreReset    (coreReset),
    .isReady      (isReady),
    .lockLossCount(lockLossCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExpect(input int edgeNum, input logic pr, input logic cr, input logic rdy,
                            input logic [3:0] cnt);
    expT e;
    e.edgeNum = edgeNum;
    e.outs    = {pr, cr, rdy, cnt};
    sb.push_back(e);
  endtask

  // Drives inputs just after an edge, then lets the given number of edges pass.
  task automatic applyStimulus(input logic rst, input logic lock, input logic req, input int edges);
    reset     = rst;
    pllLocked = lock;
    resetReq  = req;
    repeat (edges) @(posedge clk);
    #1;
  endtask

  // Lock drop in RUN, then restore: loss seen 3 edges after the drop, full re-sequence.
  task automatic lossCycle(input logic [3:0] expCnt);
    int c;
    int b;
    c = cyc;
    pushExpect(c + 3, 1'b1, 1'b1, 1'b0, expCnt);
    applyStimulus(1'b0, 1'b0, 1'b0, 5);
    b = cyc;
    pushExpect(b + 11, 1'b0, 1'b1, 1'b0, expCnt);
    pushExpect(b + 15, 1'b0, 1'b0, 1'b1, expCnt);
    applyStimulus(1'b0, 1'b1, 1'b0, 18);
  endtask

  always @(negedge clk) begin
    logic [6:0] outs;
    expT        e;
    if (cyc > 0) begin
      outs = {periphReset, coreReset, isReady, lockLossCount};
      if (outs !== prevOuts) begin
        if (sb.size() == 0) begin
          checkOutput($sformatf("unexpected_change_ev%0d", evIdx), {25'd0, outs}, {25'd0, prevOuts});
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("edge_ev%0d", evIdx), cyc, e.edgeNum);
          checkOutput($sformatf("outs_ev%0d", evIdx), {25'd0, outs}, {25'd0, e.outs});
        end
        evIdx++;
      end
      prevOuts = outs;
      checkOutput("ordering_core_before_periph", {31'd0, (!coreReset && periphReset)}, 32'd0);
    end
  end

  initial begin
    int c;
    int b;

    // Reset state, then power-up with lock held high.
    pushExpect(1, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3);
    b = cyc;
    pushExpect(b + 11, 1'b0, 1'b1, 1'b0, 4'd0);
    pushExpect(b + 15, 1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 18);

    // 17 loss/recover cycles; counter saturates at 15.
    for (int k = 1; k <= 17; k++) begin
      lossCycle((k > 15) ? 4'd15 : 4'(k));
    end

    // One-cycle lock glitch mid-STABILIZE restarts the window.
    c = cyc;
    pushExpect(c + 3, 1'b1, 1'b1, 1'b0, 4'd15);
    applyStimulus(1'b0, 1'b0, 1'b0, 5);
    b = cyc;
    pushExpect(b + 17, 1'b0, 1'b1, 1'b0, 4'd15);
    pushExpect(b + 21, 1'b0, 1'b0, 1'b1, 4'd15);
    applyStimulus(1'b0, 1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 20);

    // Single resetReq pulse in RUN.
    c = cyc;
    pushExpect(c + 1, 1'b1, 1'b1, 1'b0, 4'd15);
    pushExpect(c + 13, 1'b0, 1'b1, 1'b0, 4'd15);
    pushExpect(c + 17, 1'b0, 1'b0, 1'b1, 4'd15);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 19);

    // Second pulse mid-HOLD restarts the hold count.
    c = cyc;
    pushExpect(c + 1, 1'b1, 1'b1, 1'b0, 4'd15);
    pushExpect(c + 15, 1'b0, 1'b1, 1'b0, 4'd15);
    pushExpect(c + 19, 1'b0, 1'b0, 1'b1, 4'd15);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 19);

    // Synchronous reset while in RELEASE_PERIPH clears everything including the count.
    c = cyc;
    pushExpect(c + 1, 1'b1, 1'b1, 1'b0, 4'd15);
    pushExpect(c + 13, 1'b0, 1'b1, 1'b0, 4'd15);
    pushExpect(c + 15, 1'b1, 1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 13);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    b = cyc;
    pushExpect(b + 11, 1'b0, 1'b1, 1'b0, 4'd0);
    pushExpect(b + 15, 1'b0, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 18);

    // Counting restarts from zero after the reset.
    lossCycle(4'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3);

    checkOutput("pending_expectations", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the IceBreaker PLL (12 MHz in, 42 MHz out) and runs in the PLL output clock domain.
- Consumes the PLL lock indication and produces staggered, glitch-free, registered resets for the peripheral bus and the J1 core.
- Inputs are the PLL lock and an optional software reset request.
- If lock is lost, it pulls the design back into reset and counts the loss events.

Parameters:
- SYNC_STAGES, 2, flip-flops in the pllLocked synchroniser (minimum 2).
- STABLE_CYCLES, 4200, consecutive synchronised-lock cycles required before any reset is released (100 us at 42 MHz).
- STAGGER_CYCLES, 16, cycles between periphReset release and coreReset release.
- HOLD_CYCLES, 8, minimum reset assertion after a resetReq pulse.
- LOSS_CNT_WIDTH, 4, width of the lock-loss counter.

Ports:
- clk  in  1  system clock (PLL clkOut, 42 MHz)
- reset  in  1  synchronous, active-high reset
- pllLocked  in  1  PLL isLocked; asynchronous to clk, synchronised internally
- resetReq  in  1  synchronous single-cycle request to re-run the reset sequence
- periphReset  out  1  active-high reset for peripherals (released first)
- coreReset  out  1  active-high reset for J1 core (released last)
- isReady  out  1  high only in RUN
- lockLossCount  out  LOSS_CNT_WIDTH  saturating count of lock losses seen in RUN

Behaviour:
- Synchronous, active-high reset; it has priority over everything else.
  - Synchroniser chain cleared to 0; state WAIT_LOCK; counter 0.
  - Outputs: periphReset=1, coreReset=1, isReady=0, lockLossCount=0.
- All outputs are registered; no combinational path from any input to any output.
- lockSync is the last synchroniser flop, i.e. pllLocked delayed by SYNC_STAGES edges.
- One shared counter, width clog2(max(STABLE_CYCLES, STAGGER_CYCLES, HOLD_CYCLES)).
- States and transitions (each bullet evaluated on a clock edge, listed in priority order within a state):
  - WAIT_LOCK: resets held high. lockSync=1 -> STABILIZE, cnt=0.
  - STABILIZE: lockSync=0 -> WAIT_LOCK (debounce restart). Otherwise, cnt==STABLE_CYCLES-1 -> RELEASE_PERIPH, periphReset<=0, cnt=0. Otherwise cnt++. STABILIZE therefore lasts exactly STABLE_CYCLES edges.
  - RELEASE_PERIPH: lockSync=0 -> WAIT_LOCK, periphReset<=1, no count increment. Otherwise, cnt==STAGGER_CYCLES-1 -> RUN, coreReset<=0, isReady<=1. Otherwise cnt++.
  - RUN: lockSync=0 -> WAIT_LOCK; periphReset, coreReset <=1 and isReady<=0 on that same edge; lockLossCount++ (saturating at all ones).
  - HOLD: resets high, isReady=0. cnt==HOLD_CYCLES-1 -> WAIT_LOCK. Otherwise cnt++.
- resetReq=1 in any state -> HOLD, cnt=0, both resets <=1, isReady<=0.
  - Overrides the lock-driven transitions above.
  - resetReq during HOLD restarts the hold count.
  - resetReq and lock loss on the same RUN edge: state goes to HOLD, and lockLossCount still increments.
- Reset ordering invariant: coreReset=0 implies periphReset=0. Reset assertion is simultaneous for both signals; release is always periph first, then core.
- A lockSync glitch of any length during STABILIZE restarts the full STABLE_CYCLES window.

Test Plan (bench parameters: SYNC_STAGES=2, STABLE_CYCLES=8, STAGGER_CYCLES=4, HOLD_CYCLES=3; edge 1 = first edge with reset=0):
- Power-up: pllLocked held 1 throughout, reset released before edge 1 -> STABILIZE entered at edge 3, periphReset falls after edge 11, coreReset and isReady change after edge 15, lockLossCount=0.
- Lock glitch: pllLocked low for 1 cycle mid-STABILIZE -> periphReset stays 1. Release occurs 8 STABILIZE edges after lockSync returns high, plus 1 WAIT_LOCK edge.
- Lock loss in RUN: drop pllLocked -> both resets =1 and isReady=0 three edges later. lockLossCount=1. Restore lock -> full sequence re-runs.
- Saturation: 17 loss/recover cycles with LOSS_CNT_WIDTH=4 -> lockLossCount stops at 15.
- resetReq in RUN: single pulse -> resets high next edge, HOLD for 3 edges, then normal sequence. A second pulse mid-HOLD extends HOLD by the restart amount.
- Synchronous reset mid-RELEASE_PERIPH: assert reset -> all outputs at reset values on the next edge, lockLossCount cleared. Check the ordering invariant throughout with an assertion.
